// File: rtl/crc_frame_engine_if.sv
// rtl/crc_frame_engine_if.sv - byte stream handshake bundle for crc_frame_engine
// Purpose: one direction of a byte stream with valid/ready flow control.
// Signals: valid (byte present), ready (byte accepted), data[7:0], last (final byte of frame).
// Modports: master drives valid/data/last and observes ready; slave is the mirror.
interface crc_frame_engine_if;
    logic       valid;
    logic       ready;
    logic [7:0] data;
    logic       last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/crc_frame_engine.sv
// rtl/crc_frame_engine.sv - parametrised frame-aware CRC generator/checker
// Purpose: passes a byte stream through a single output register, computes a CRC
//   per frame, appends it (generate mode) or checks the residue (check mode).
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   mode_i          0 = generate, 1 = check; latched on first byte of a frame
//   s               input byte stream (slave)
//   m               output byte stream (master)
//   crc_out_o       final CRC of last completed frame (register ^ XOROUT)
//   res_valid_o     one-cycle pulse when crc_out_o/crc_ok_o are updated
//   crc_ok_o        check-mode verdict of last frame
//   busy_o          frame in progress or output still pending
module crc_frame_engine #(
    parameter int               CRC_W         = 8,
    parameter logic [CRC_W-1:0] POLY          = 'h07,
    parameter logic [CRC_W-1:0] INIT          = '0,
    parameter logic [CRC_W-1:0] XOROUT        = '0,
    parameter bit               REFIN         = 1'b0,
    parameter logic [CRC_W-1:0] CHECK_RESIDUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode_i,
    crc_frame_engine_if.slave  s,
    crc_frame_engine_if.master m,
    output logic [CRC_W-1:0] crc_out_o,
    output logic             res_valid_o,
    output logic             crc_ok_o,
    output logic             busy_o
);
    localparam logic [2:0] NB_C   = 3'(CRC_W / 8);
    localparam logic [2:0] LAST_C = 3'(CRC_W / 8 - 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_END, S_APPEND} state_t;

    state_t           state_q, state_d;
    logic             mode_q, mode_d;
    logic [CRC_W-1:0] crc_q, crc_d;
    logic [CRC_W-1:0] crc_out_q, crc_out_d;
    logic             crc_ok_q, crc_ok_d;
    logic [7:0]       odata_q, odata_d;
    logic             olast_q, olast_d;
    logic             ovalid_q, ovalid_d;
    logic [2:0]       cnt_q, cnt_d;

    logic             out_free, s_fire, m_fire, mode_eff, crc_load;
    logic [CRC_W-1:0] crc_next, crc_shift;

    // Eight serial shift-left steps unrolled into one cycle.
    function automatic logic [CRC_W-1:0] crc_byte(input logic [CRC_W-1:0] c_in,
                                                  input logic [7:0] d);
        logic [CRC_W-1:0] c;
        logic             fb;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            fb = c[CRC_W-1] ^ (REFIN ? d[i] : d[7-i]);
            c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
        return c;
    endfunction

    assign out_free  = !ovalid_q || m.ready;
    assign s.ready   = !rst && (state_q == S_IDLE || state_q == S_DATA) && out_free;
    assign s_fire    = s.valid && s.ready;
    assign m_fire    = ovalid_q && m.ready;
    // Mode is taken live only on the first byte; afterwards the latched copy rules.
    assign mode_eff  = (state_q == S_IDLE) ? mode_i : mode_q;
    assign crc_next  = crc_byte(crc_q, s.data);
    // Byte cnt_q of crc_out_q counted from the most-significant end.
    assign crc_shift = crc_out_q << (8 * cnt_q);

    assign m.valid     = ovalid_q;
    assign m.data      = odata_q;
    assign m.last      = olast_q;
    assign crc_out_o   = crc_out_q;
    assign crc_ok_o    = crc_ok_q;
    assign res_valid_o = (state_q == S_END);
    assign busy_o      = (state_q != S_IDLE) || ovalid_q;

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        crc_d     = crc_q;
        crc_out_d = crc_out_q;
        crc_ok_d  = crc_ok_q;
        odata_d   = odata_q;
        olast_d   = olast_q;
        ovalid_d  = ovalid_q;
        cnt_d     = cnt_q;
        crc_load  = 1'b0;

        case (state_q)
            S_IDLE, S_DATA: begin
                if (s_fire) begin
                    mode_d  = mode_eff;
                    crc_d   = crc_next;
                    state_d = S_DATA;
                    if (s.last) begin
                        // Results are latched here so they are already valid
                        // during the res_valid pulse in END.
                        state_d   = S_END;
                        crc_d     = INIT;
                        crc_out_d = crc_next ^ XOROUT;
                        crc_ok_d  = mode_eff && (crc_next == CHECK_RESIDUE);
                    end
                end
            end
            S_END: begin
                if (mode_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d  = S_APPEND;
                    crc_load = out_free;
                end
            end
            S_APPEND: begin
                crc_load = (cnt_q < NB_C) && out_free;
                if (m_fire && olast_q) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (s_fire) begin
            odata_d  = s.data;
            olast_d  = mode_eff && s.last;
            ovalid_d = 1'b1;
        end else if (crc_load) begin
            odata_d  = crc_shift[CRC_W-1 -: 8];
            olast_d  = (cnt_q == LAST_C);
            ovalid_d = 1'b1;
            cnt_d    = cnt_q + 3'd1;
        end else if (m_fire) begin
            ovalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            mode_q    <= 1'b0;
            crc_q     <= INIT;
            crc_out_q <= '0;
            crc_ok_q  <= 1'b0;
            odata_q   <= '0;
            olast_q   <= 1'b0;
            ovalid_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            crc_q     <= crc_d;
            crc_out_q <= crc_out_d;
            crc_ok_q  <= crc_ok_d;
            odata_q   <= odata_d;
            olast_q   <= olast_d;
            ovalid_q  <= ovalid_d;
            cnt_q     <= cnt_d;
        end
    end
endmodule

// File: tb/tb_crc_frame_engine.sv
// tb/tb_crc_frame_engine.sv - self-checking bench for crc_frame_engine
module tb_crc_frame_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        mode8, mode16;
    logic [7:0]  crc_out8;
    logic [15:0] crc_out16;
    logic        res8, res16, ok8, ok16, busy8, busy16;

    crc_frame_engine_if s8();
    crc_frame_engine_if m8();
    crc_frame_engine_if s16();
    crc_frame_engine_if m16();

    crc_frame_engine #(.CRC_W(8), .POLY(8'h07), .INIT(8'h00), .XOROUT(8'h00),
                       .REFIN(1'b0), .CHECK_RESIDUE(8'h00)) dut8 (
        .clk(clk), .rst(rst), .mode_i(mode8), .s(s8), .m(m8),
        .crc_out_o(crc_out8), .res_valid_o(res8), .crc_ok_o(ok8), .busy_o(busy8));

    crc_frame_engine #(.CRC_W(16), .POLY(16'h1021), .INIT(16'hFFFF), .XOROUT(16'h0000),
                       .REFIN(1'b0), .CHECK_RESIDUE(16'h0000)) dut16 (
        .clk(clk), .rst(rst), .mode_i(mode16), .s(s16), .m(m16),
        .crc_out_o(crc_out16), .res_valid_o(res16), .crc_ok_o(ok16), .busy_o(busy16));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Monitors sample on the falling edge, between input drive and transfer edge.
    int         nc = 0;
    int         last_in_nc8 = 0, res_nc8 = 0, res_cnt8 = 0, viol8 = 0, res_cnt16 = 0;
    logic [8:0] out8[$];
    logic [8:0] out16[$];
    int         out_nc8[$];
    logic       ok_hist8[$];
    logic       app8 = 1'b0, first8 = 1'b1, cur_mode8 = 1'b0;
    logic       rnd8 = 1'b0;

    always @(negedge clk) begin
        nc++;
        if (rst) begin
            app8   = 1'b0;
            first8 = 1'b1;
        end else begin
            if (s8.valid && s8.ready) begin
                if (first8) cur_mode8 = mode8;
                first8 = s8.last;
                if (s8.last) last_in_nc8 = nc;
            end
            if ((res8 || app8) && s8.ready) viol8++;
            if (res8) begin
                res_cnt8++;
                res_nc8 = nc;
                ok_hist8.push_back(ok8);
                if (!cur_mode8) app8 = 1'b1;
            end
            if (m8.valid && m8.ready) begin
                out8.push_back({m8.last, m8.data});
                out_nc8.push_back(nc);
                if (m8.last) app8 = 1'b0;
            end
            if (res16) res_cnt16++;
            if (m16.valid && m16.ready) out16.push_back({m16.last, m16.data});
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (rnd8) m8.ready = 1'($urandom_range(0, 1));
    end

    logic [7:0] fr8[$];
    logic [7:0] fr16[$];

    function automatic logic [7:0] m_crc8(input logic [7:0] c_in, input logic [7:0] d);
        logic [7:0] c;
        logic       fb;
        c = c_in;
        for (int i = 7; i >= 0; i--) begin
            fb = c[7] ^ d[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    // Called and returns at posedge+1.
    task automatic send8(input logic md, input bit gaps);
        logic sent;
        int   to;
        mode8 = md;
        for (int i = 0; i < fr8.size(); i++) begin
            if (gaps) begin
                while ($urandom_range(0, 2) == 0) begin
                    s8.valid = 1'b0;
                    @(posedge clk);
                    #1;
                end
            end
            s8.valid = 1'b1;
            s8.data  = fr8[i];
            s8.last  = (i == fr8.size() - 1);
            to = 0;
            sent = 1'b0;
            while (!sent && to < 500) begin
                @(negedge clk);
                sent = s8.ready;
                @(posedge clk);
                #1;
                to++;
            end
            if (!sent) begin
                chk("send8_timeout", 32'd0, 32'd1);
                break;
            end
        end
        s8.valid = 1'b0;
        s8.last  = 1'b0;
    endtask

    task automatic send16(input logic md);
        logic sent;
        int   to;
        mode16 = md;
        for (int i = 0; i < fr16.size(); i++) begin
            s16.valid = 1'b1;
            s16.data  = fr16[i];
            s16.last  = (i == fr16.size() - 1);
            to = 0;
            sent = 1'b0;
            while (!sent && to < 500) begin
                @(negedge clk);
                sent = s16.ready;
                @(posedge clk);
                #1;
                to++;
            end
            if (!sent) begin
                chk("send16_timeout", 32'd0, 32'd1);
                break;
            end
        end
        s16.valid = 1'b0;
        s16.last  = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((busy8 || busy16) && t < 2000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 2000) chk("idle_timeout", 32'd0, 32'd1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        out8.delete();
        out_nc8.delete();
        out16.delete();
        ok_hist8.delete();
        res_cnt8  = 0;
        res_cnt16 = 0;
        viol8     = 0;
    endtask

    string      digits = "123456789";
    logic [8:0] exp8[$];
    logic       exp_ok[$];
    int         mm;
    logic [7:0] c, b;
    int         len;
    logic       md;

    initial begin
        s8.valid = 1'b0;  s8.data = '0;  s8.last = 1'b0;  m8.ready = 1'b1;
        s16.valid = 1'b0; s16.data = '0; s16.last = 1'b0; m16.ready = 1'b1;
        mode8 = 1'b0; mode16 = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_ready", 32'(s8.ready), 32'd0);
        chk("rst_m_valid", 32'(m8.valid), 32'd0);
        chk("rst_m_data", 32'(m8.data), 32'd0);
        chk("rst_m_last", 32'(m8.last), 32'd0);
        chk("rst_crc_out", 32'(crc_out16), 32'd0);
        chk("rst_crc_ok", 32'(ok8), 32'd0);
        chk("rst_res_valid", 32'(res8), 32'd0);
        chk("rst_busy", 32'(busy8), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("s_ready_after_rst", 32'(s8.ready), 32'd1);

        // Generate CRC-8 over "123456789"
        clear_logs();
        fr8.delete();
        for (int i = 0; i < digits.len(); i++) fr8.push_back(digits[i]);
        send8(1'b0, 1'b0);
        wait_idle();
        chk("gen8_len", 32'(out8.size()), 32'd10);
        mm = 0;
        for (int i = 0; i < 9; i++) begin
            b = digits[i];
            if (out8[i] !== {1'b0, b}) mm++;
        end
        chk("gen8_data_mism", 32'(mm), 32'd0);
        chk("gen8_crc_byte", 32'(out8[9]), 32'h1F4);
        chk("gen8_crc_out", 32'(crc_out8), 32'hF4);
        chk("gen8_crc_ok", 32'(ok8), 32'd0);
        chk("gen8_res_cnt", 32'(res_cnt8), 32'd1);
        chk("gen8_res_lat", 32'(res_nc8 - last_in_nc8), 32'd1);
        chk("gen8_crc_lat", 32'(out_nc8[9] - last_in_nc8), 32'd2);
        chk("gen8_thruput", 32'(out_nc8[8] - out_nc8[0]), 32'd8);

        // Generate CRC-16/1021 init FFFF over "123456789"
        clear_logs();
        fr16.delete();
        for (int i = 0; i < digits.len(); i++) fr16.push_back(digits[i]);
        send16(1'b0);
        wait_idle();
        chk("gen16_len", 32'(out16.size()), 32'd11);
        chk("gen16_crc_hi", 32'(out16[9]), 32'h029);
        chk("gen16_crc_lo", 32'(out16[10]), 32'h1B1);
        chk("gen16_crc_out", 32'(crc_out16), 32'h29B1);
        chk("gen16_res_cnt", 32'(res_cnt16), 32'd1);

        // Check mode, good frame
        clear_logs();
        fr8.delete();
        for (int i = 0; i < digits.len(); i++) fr8.push_back(digits[i]);
        fr8.push_back(8'hF4);
        send8(1'b1, 1'b0);
        wait_idle();
        chk("chk_good_len", 32'(out8.size()), 32'd10);
        mm = 0;
        for (int i = 0; i < 10; i++) if (out8[i] !== {(i == 9), fr8[i]}) mm++;
        chk("chk_good_stream_mism", 32'(mm), 32'd0);
        chk("chk_good_ok", 32'(ok8), 32'd1);
        chk("chk_good_res_cnt", 32'(res_cnt8), 32'd1);

        // Check mode, corrupted frame
        clear_logs();
        fr8[2] = 8'h30;
        send8(1'b1, 1'b0);
        wait_idle();
        chk("chk_bad_ok", 32'(ok8), 32'd0);
        chk("chk_bad_res_cnt", 32'(res_cnt8), 32'd1);
        chk("chk_bad_last", 32'(out8[9]), 32'h1F4);

        // Single-byte frame followed immediately by another
        clear_logs();
        fr8.delete();
        fr8.push_back(8'h00);
        send8(1'b0, 1'b0);
        fr8.delete();
        fr8.push_back(8'h01);
        send8(1'b0, 1'b0);
        wait_idle();
        chk("single_len", 32'(out8.size()), 32'd4);
        chk("single_b0", 32'(out8[0]), 32'h000);
        chk("single_b1", 32'(out8[1]), 32'h100);
        chk("single_b2", 32'(out8[2]), 32'h001);
        chk("single_b3", 32'(out8[3]), 32'h107);
        chk("single_res_cnt", 32'(res_cnt8), 32'd2);
        chk("single_crc_out", 32'(crc_out8), 32'h07);

        // Reset during APPEND after the first CRC byte
        clear_logs();
        fr16.delete();
        fr16.push_back(8'hA5);
        send16(1'b0);
        begin
            int t = 0;
            while (out16.size() < 2 && t < 50) begin
                @(posedge clk);
                #1;
                t++;
            end
            if (t >= 50) chk("append_wait_timeout", 32'd0, 32'd1);
        end
        m16.ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m16.ready = 1'b1;
        chk("rst_app_m_valid", 32'(m16.valid), 32'd0);
        chk("rst_app_busy", 32'(busy16), 32'd0);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        chk("rst_app_out_len", 32'(out16.size()), 32'd2);
        clear_logs();
        fr16.delete();
        for (int i = 0; i < digits.len(); i++) fr16.push_back(digits[i]);
        send16(1'b0);
        wait_idle();
        chk("post_rst_len", 32'(out16.size()), 32'd11);
        chk("post_rst_crc_out", 32'(crc_out16), 32'h29B1);
        chk("post_rst_crc_lo", 32'(out16[10]), 32'h1B1);

        // Random frames, random gaps and back-pressure
        clear_logs();
        exp8.delete();
        exp_ok.delete();
        rnd8 = 1'b1;
        for (int f = 0; f < 20; f++) begin
            fr8.delete();
            len = $urandom_range(1, 6);
            md  = 1'($urandom_range(0, 1));
            for (int i = 0; i < len; i++) fr8.push_back(8'($urandom_range(0, 255)));
            c = 8'h00;
            foreach (fr8[i]) c = m_crc8(c, fr8[i]);
            if (md && $urandom_range(0, 1) == 1) begin
                fr8.push_back(c);
                c = m_crc8(c, c);
            end
            for (int i = 0; i < fr8.size(); i++)
                exp8.push_back({md && (i == fr8.size() - 1), fr8[i]});
            if (!md) exp8.push_back({1'b1, c});
            exp_ok.push_back(md && (c == 8'h00));
            send8(md, 1'b1);
        end
        wait_idle();
        rnd8 = 1'b0;
        m8.ready = 1'b1;
        chk("rand_len", 32'(out8.size()), 32'(exp8.size()));
        mm = 0;
        for (int i = 0; i < exp8.size(); i++) if (out8[i] !== exp8[i]) mm++;
        chk("rand_stream_mism", 32'(mm), 32'd0);
        chk("rand_res_cnt", 32'(res_cnt8), 32'd20);
        mm = 0;
        for (int i = 0; i < exp_ok.size(); i++) if (ok_hist8[i] !== exp_ok[i]) mm++;
        chk("rand_ok_mism", 32'(mm), 32'd0);
        chk("rand_s_ready_in_end_append", 32'(viol8), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/crc_frame_engine.md
# crc_frame_engine

Parametrised, frame-aware CRC engine. It succeeds the fixed 8-bit CRC generator/checker and supports configurable CRC width, polynomial, init, output XOR and input bit order. A byte stream passes through with valid/ready handshakes. In generate mode the engine appends the CRC bytes to each frame. In check mode it verifies a frame that ends in its CRC and reports pass/fail per frame. It sits between a packet source and the link/serialiser.

## Interface
Parameters:
- CRC_W, 8, CRC width in bits; must be 8, 16 or 32.
- POLY, 'h07, generator polynomial, implicit top bit omitted.
- INIT, 0, CRC register value at the start of each frame.
- XOROUT, 0, XOR applied to the register to form the final CRC.
- REFIN, 0, bit order: 1 = data bit 0 enters first; 0 = bit 7 first.
- CHECK_RESIDUE, 0, raw register value that indicates a good frame in check mode.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- mode  in  1  0 = generate, 1 = check; sampled on the first accepted byte of a frame.
- s_valid  in  1  input byte valid.
- s_ready  out  1  engine accepts the input byte.
- s_data  in  8  input byte.
- s_last  in  1  last byte of frame (in check mode, the last CRC byte).
- m_valid  out  1  output byte valid.
- m_ready  in  1  downstream accepts the output byte.
- m_data  out  8  output byte.
- m_last  out  1  last byte of output frame.
- crc_out  out  CRC_W  final CRC of the last completed frame (register ^ XOROUT).
- res_valid  out  1  one-cycle pulse: crc_out and crc_ok are updated.
- crc_ok  out  1  check-mode result of the last frame; 0 after a generate-mode frame.
- busy  out  1  high from the first accepted byte until the frame is fully emitted.

## Operation
- Input transfer occurs on s_valid && s_ready. Output transfer occurs on m_valid && m_ready.
- CRC update per accepted byte: 8 serial steps, MSB-first shift-left register. Each step computes fb = reg[CRC_W-1] ^ databit, then reg = (reg<<1) ^ (fb ? POLY : 0).
- Bit order within the byte is set by REFIN. Bits are consumed in a single cycle, combinationally unrolled.
- States:
  - IDLE: reg = INIT. The first accepted byte latches mode and moves to DATA, or to END if s_last is set.
  - DATA: accept and forward bytes. An accepted byte with s_last goes to END.
  - END (1 cycle): crc_out <= reg ^ XOROUT. crc_ok <= mode && (reg == CHECK_RESIDUE). Pulse res_valid. Next state is APPEND in generate mode, IDLE in check mode.
  - APPEND: emit CRC_W/8 bytes of crc_out, most-significant byte first, using a byte counter. m_last is set on the final byte. After that byte transfers, go to IDLE.
- Pass-through: each accepted byte is loaded into a single output register. m_last = s_last in check mode; m_last = 0 on data bytes in generate mode.
- s_ready = (state is IDLE or DATA) && (!m_valid || m_ready). The engine deasserts s_ready during END and APPEND.
- A mode change mid-frame is ignored until the next IDLE.
- crc_out and crc_ok hold their values until the next END.

## Timing
- Reset values: s_ready 0 during rst, then 1 the cycle after. m_valid 0, m_data 0, m_last 0, crc_out 0, crc_ok 0, res_valid 0, busy 0. State IDLE, reg = INIT.
- Pass-through latency: 1 cycle from input transfer to m_valid. With m_ready held high, throughput is 1 byte/cycle.
- res_valid pulses exactly 1 cycle after the s_last byte transfer.
- Generate mode: the first CRC byte is valid 2 cycles after the s_last transfer when m_ready is held high. A frame of N bytes emits N + CRC_W/8 bytes.
- Back-pressure: with m_ready low, m_valid, m_data and m_last are held stable and s_ready is 0. No byte is lost or duplicated.
- Single-byte frame (s_last on the first byte) is legal.
- Back-to-back frames: the next frame's first byte may transfer in the cycle after IDLE is re-entered, with no extra gap beyond END/APPEND.
- rst mid-frame or mid-APPEND: the frame is abandoned, the output register is cleared, and res_valid is not pulsed. The engine returns to IDLE the next cycle.

## Test plan
- CRC_W=8, POLY 'h07, INIT 0, XOROUT 0, REFIN 0; generate on ASCII "123456789" -> crc_out 'hF4, res_valid 1 pulse, output is the 9 bytes then 'hF4 with m_last.
- CRC_W=16, POLY 'h1021, INIT 'hFFFF, REFIN 0; generate on "123456789" -> crc_out 'h29B1, appended bytes 'h29 then 'hB1.
- Check mode, CRC_W=8 config; input "123456789" + 'hF4 with s_last -> crc_ok 1. Same frame with byte 3 flipped to 'h30 -> crc_ok 0. Output equals the input with m_last on 'hF4.
- Random m_ready (50%) and random s_valid gaps across 20 random frames in both modes -> output stream matches the reference model byte-exact; s_ready is never high in END/APPEND.
- Single-byte frame 'h00 in generate mode, followed immediately by a second frame -> two END pulses, and each frame's CRC is appended before the next frame's bytes.
- rst asserted during APPEND after the first CRC byte -> no further bytes, m_valid 0 next cycle; the next frame computes from INIT correctly.
